exec_mem_unit: RTL and testbench

- Combined execute/memory block for the rv32i single-cycle core: ALU, 4 KiB byte-enabled data RAM, and load byte reader.
- The ALU result is the data-RAM read address. The byte reader turns the raw read word into the register write-back value for LB/LH/LW/LBU/LHU.
- Sits between the register file/sign-extender and the write-back mux. Stores come in via an external write port, which the core drives from its load/store decoder or a loader.

---
 rtl/exec_mem_unit.sv | 141 ++++++++++++++
 tb/tb_exec_mem_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/exec_mem_unit.sv
// Execute/memory stage of the rv32i single-cycle core: ALU, byte-enabled data RAM
// with combinational read, and the load byte reader feeding write-back.
module exec_mem_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            alu_ctrl,
    input  logic                  alu_src,
    input  logic [DATA_WIDTH-1:0] src1,
    input  logic [DATA_WIDTH-1:0] src2,
    input  logic [DATA_WIDTH-1:0] sign_ext,
    output logic [DATA_WIDTH-1:0] results,
    output logic                  zero,
    output logic                  res_last_bit,
    input  logic [11:0]           w_addr,
    input  logic [DATA_WIDTH-1:0] w_dat,
    input  logic                  w_enb,
    input  logic [3:0]            byte_enb,
    input  logic                  r_enb,
    output logic [DATA_WIDTH-1:0] r_dat,
    input  logic [2:0]            func3,
    input  logic [3:0]            byte_mask,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  valid,
    input  logic [11:0]           debug_addr,
    output logic [DATA_WIDTH-1:0] debug_data
);

    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    typedef enum logic [2:0] {
        LD_B  = 3'b000,
        LD_H  = 3'b001,
        LD_W  = 3'b010,
        LD_BU = 3'b100,
        LD_HU = 3'b101
    } load_e;

    logic [DATA_WIDTH-1:0] op_b;
    logic [4:0]            shamt;

    assign op_b  = alu_src ? sign_ext : src2;
    assign shamt = op_b[4:0];

    always_comb begin
        results = '0;
        case (alu_op_e'(alu_ctrl))
            ALU_ADD:  results = src1 + op_b;
            ALU_SUB:  results = src1 - op_b;
            ALU_AND:  results = src1 & op_b;
            ALU_OR:   results = src1 | op_b;
            ALU_XOR:  results = src1 ^ op_b;
            ALU_SLL:  results = src1 << shamt;
            ALU_SRL:  results = src1 >> shamt;
            ALU_SRA:  results = $signed(src1) >>> shamt;
            ALU_SLT:  results = {{(DATA_WIDTH-1){1'b0}}, $signed(src1) < $signed(op_b)};
            ALU_SLTU: results = {{(DATA_WIDTH-1){1'b0}}, src1 < op_b};
            default:  results = '0;
        endcase
    end

    assign zero         = (results == '0);
    assign res_last_bit = results[0];

    // Contents start at zero and are never cleared by rst.
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH] = '{default: '0};

    logic [AW-1:0] w_word;
    logic [AW-1:0] r_word;
    logic [AW-1:0] d_word;

    assign w_word = w_addr[AW+1:2];
    assign r_word = results[AW+1:2];
    assign d_word = debug_addr[AW+1:2];

    always_ff @(posedge clk) begin
        if (w_enb && !rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byte_enb[i])
                    mem[w_word][8*i +: 8] <= w_dat[8*i +: 8];
            end
        end
    end

    assign r_dat      = (r_enb && !rst) ? mem[r_word] : '0;
    assign debug_data = mem[d_word];

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic        byte_ok;
    logic        half_ok;

    always_comb begin
        sel_byte = '0;
        sel_half = '0;
        byte_ok  = 1'b0;
        half_ok  = 1'b0;
        case (byte_mask)
            4'b0001: begin sel_byte = r_dat[7:0];   byte_ok = 1'b1; end
            4'b0010: begin sel_byte = r_dat[15:8];  byte_ok = 1'b1; end
            4'b0100: begin sel_byte = r_dat[23:16]; byte_ok = 1'b1; end
            4'b1000: begin sel_byte = r_dat[31:24]; byte_ok = 1'b1; end
            4'b0011: begin sel_half = r_dat[15:0];  half_ok = 1'b1; end
            4'b1100: begin sel_half = r_dat[31:16]; half_ok = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        wb_data = '0;
        valid   = 1'b0;
        case (load_e'(func3))
            LD_B:  if (byte_ok) begin valid = 1'b1; wb_data = {{24{sel_byte[7]}}, sel_byte}; end
            LD_BU: if (byte_ok) begin valid = 1'b1; wb_data = {24'h0, sel_byte}; end
            LD_H:  if (half_ok) begin valid = 1'b1; wb_data = {{16{sel_half[15]}}, sel_half}; end
            LD_HU: if (half_ok) begin valid = 1'b1; wb_data = {16'h0, sel_half}; end
            LD_W:  if (byte_mask == 4'b1111) begin valid = 1'b1; wb_data = r_dat; end
            default: ;
        endcase
    end

    // Address bits outside the word index are deliberately ignored (addresses wrap).
    logic unused_bits;
    assign unused_bits = ^{w_addr[1:0], debug_addr[1:0], results[DATA_WIDTH-1:AW+2], results[1:0]};

endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed scoreboard bench for exec_mem_unit: expectations are queued as stimulus is
// applied and popped against the combinational outputs once they have settled.
module tb_exec_mem_unit;

    logic        clk;
    logic        rst;
    logic [3:0]  alu_ctrl;
    logic        alu_src;
    logic [31:0] src1, src2, sign_ext;
    logic [31:0] results;
    logic        zero, res_last_bit;
    logic [11:0] w_addr;
    logic [31:0] w_dat;
    logic        w_enb;
    logic [3:0]  byte_enb;
    logic        r_enb;
    logic [31:0] r_dat;
    logic [2:0]  func3;
    logic [3:0]  byte_mask;
    logic [31:0] wb_data;
    logic        valid;
    logic [11:0] debug_addr;
    logic [31:0] debug_data;

    exec_mem_unit #(.DATA_WIDTH(32), .MEM_DEPTH(1024)) dut (
        .clk(clk), .rst(rst), .alu_ctrl(alu_ctrl), .alu_src(alu_src),
        .src1(src1), .src2(src2), .sign_ext(sign_ext),
        .results(results), .zero(zero), .res_last_bit(res_last_bit),
        .w_addr(w_addr), .w_dat(w_dat), .w_enb(w_enb), .byte_enb(byte_enb),
        .r_enb(r_enb), .r_dat(r_dat), .func3(func3), .byte_mask(byte_mask),
        .wb_data(wb_data), .valid(valid),
        .debug_addr(debug_addr), .debug_data(debug_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int { S_RES, S_ZERO, S_LSB, S_RDAT, S_WB, S_VALID, S_DBG } sig_e;

    typedef struct {
        string       tag;
        sig_e        sel;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb[$];
    int n_asserts = 0;
    int n_fail    = 0;

    task automatic expect_val(input string tag, input sig_e sel, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.sel = sel;
        it.exp = exp;
        sb.push_back(it);
    endtask

    function automatic logic [31:0] observe(input sig_e sel);
        case (sel)
            S_RES:   return results;
            S_ZERO:  return {31'h0, zero};
            S_LSB:   return {31'h0, res_last_bit};
            S_RDAT:  return r_dat;
            S_WB:    return wb_data;
            S_VALID: return {31'h0, valid};
            S_DBG:   return debug_data;
            default: return 'x;
        endcase
    endfunction

    task automatic check_now();
        sb_item_t    it;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            it  = sb.pop_front();
            obs = observe(it.sel);
            n_asserts++;
            assert (obs === it.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
            end
        end
    endtask

    // Compare on the falling edge, well away from the write edge.
    task automatic step();
        @(negedge clk);
        check_now();
    endtask

    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        w_addr   = a;
        w_dat    = d;
        byte_enb = be;
        w_enb    = 1'b1;
        @(posedge clk);
        #1;
        w_enb = 1'b0;
    endtask

    task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_ctrl = op;
        alu_src  = 1'b0;
        src1     = a;
        src2     = b;
    endtask

    task automatic load(input logic [2:0] f3, input logic [3:0] m);
        func3     = f3;
        byte_mask = m;
    endtask

    initial begin
        rst = 1'b1; alu_ctrl = 4'b0000; alu_src = 1'b0;
        src1 = '0; src2 = '0; sign_ext = '0;
        w_addr = '0; w_dat = '0; w_enb = 1'b0; byte_enb = '0;
        r_enb = 1'b1; func3 = 3'b010; byte_mask = 4'b1111; debug_addr = '0;

        repeat (2) @(posedge clk);
        expect_val("rst_rdat", S_RDAT, 32'h0);
        expect_val("rst_wb", S_WB, 32'h0);
        expect_val("rst_valid", S_VALID, 32'h1);
        expect_val("rst_zero", S_ZERO, 32'h1);
        step();
        @(negedge clk);
        rst = 1'b0;

        do_write(12'h000, 32'h00000001, 4'b1111);
        do_write(12'h004, 32'h00000002, 4'b1111);
        alu(4'b0000, 32'h0, 32'h0); load(3'b010, 4'b1111);
        expect_val("lw0_wb", S_WB, 32'h1);
        expect_val("lw0_valid", S_VALID, 32'h1);
        step();
        alu(4'b0000, 32'h4, 32'h0);
        expect_val("lw4_wb", S_WB, 32'h2);
        expect_val("lw4_valid", S_VALID, 32'h1);
        step();
        alu(4'b0000, 32'h1, 32'h2);
        expect_val("add_res", S_RES, 32'h3);
        expect_val("add_zero", S_ZERO, 32'h0);
        expect_val("add_lsb", S_LSB, 32'h1);
        step();
        do_write(12'h00C, 32'h00000003, 4'b1111);
        debug_addr = 12'h00C;
        expect_val("dbg_c", S_DBG, 32'h3);
        step();

        alu(4'b0001, 32'hFFFFFFF0, 32'h10); expect_val("sub", S_RES, 32'hFFFFFFE0); step();
        alu(4'b0000, 32'hFFFFFFF0, 32'h10);
        expect_val("add_wrap", S_RES, 32'h0);
        expect_val("add_wrap_zero", S_ZERO, 32'h1);
        step();
        alu(4'b1000, 32'hFFFFFFF0, 32'h10); expect_val("slt", S_RES, 32'h1); step();
        alu(4'b1001, 32'hFFFFFFF0, 32'h10); expect_val("sltu", S_RES, 32'h0); step();
        alu(4'b0111, 32'hFFFFFFF0, 32'h4); expect_val("sra", S_RES, 32'hFFFFFFFF); step();
        alu(4'b0110, 32'hFFFFFFF0, 32'h4); expect_val("srl", S_RES, 32'h0FFFFFFF); step();
        alu(4'b0101, 32'hFFFFFFF0, 32'h4); expect_val("sll", S_RES, 32'hFFFFFF00); step();
        alu(4'b0010, 32'hFFFFFFF0, 32'h10); expect_val("and", S_RES, 32'h00000010); step();
        alu(4'b0011, 32'hFFFFFFF0, 32'h10); expect_val("or", S_RES, 32'hFFFFFFF0); step();
        alu(4'b0100, 32'hFFFFFFF0, 32'h10); expect_val("xor", S_RES, 32'hFFFFFFE0); step();
        alu(4'b1010, 32'hFFFFFFF0, 32'h10); expect_val("illegal_op", S_RES, 32'h0); step();
        alu(4'b0000, 32'hFFFFFFF0, 32'h10); alu_src = 1'b1; sign_ext = 32'h5;
        expect_val("add_imm", S_RES, 32'hFFFFFFF5);
        step();
        alu_src = 1'b0;

        do_write(12'h008, 32'h11223344, 4'b1111);
        do_write(12'h008, 32'h00AA0000, 4'b0100);
        debug_addr = 12'h008;
        expect_val("byte_write", S_DBG, 32'h11AA3344);
        step();

        do_write(12'h010, 32'h80FF7F01, 4'b1111);
        alu(4'b0000, 32'h10, 32'h0);
        load(3'b000, 4'b0010); expect_val("lb_b1", S_WB, 32'h0000007F); step();
        load(3'b000, 4'b0100); expect_val("lb_b2", S_WB, 32'hFFFFFFFF); step();
        load(3'b000, 4'b0001); expect_val("lb_b0", S_WB, 32'h00000001); step();
        load(3'b100, 4'b1000); expect_val("lbu_b3", S_WB, 32'h00000080); step();
        load(3'b001, 4'b1100); expect_val("lh_hi", S_WB, 32'hFFFF80FF); step();
        load(3'b101, 4'b0011); expect_val("lhu_lo", S_WB, 32'h00007F01); step();
        load(3'b010, 4'b0110);
        expect_val("lw_misaligned_wb", S_WB, 32'h0);
        expect_val("lw_misaligned_valid", S_VALID, 32'h0);
        step();
        load(3'b011, 4'b1111);
        expect_val("bad_func3_valid", S_VALID, 32'h0);
        step();
        load(3'b010, 4'b1111);

        @(negedge clk);
        rst = 1'b1;
        do_write(12'h010, 32'hDEADBEEF, 4'b1111);
        debug_addr = 12'h010;
        expect_val("rst_rdat0", S_RDAT, 32'h0);
        expect_val("rst_nowrite", S_DBG, 32'h80FF7F01);
        expect_val("rst_lw_valid", S_VALID, 32'h1);
        step();
        rst = 1'b0;
        r_enb = 1'b0;
        expect_val("renb0_rdat", S_RDAT, 32'h0);
        expect_val("renb0_dbg", S_DBG, 32'h80FF7F01);
        step();
        r_enb = 1'b1;
        expect_val("renb1_rdat", S_RDAT, 32'h80FF7F01);
        step();

        alu(4'b0000, 32'h1000, 32'h4);
        expect_val("wrap_rdat", S_RDAT, 32'h2);
        step();

        // Read during write: old word before the edge, new word after it.
        alu(4'b0000, 32'h4, 32'h0);
        @(negedge clk);
        w_addr = 12'h004; w_dat = 32'h00000055; byte_enb = 4'b1111; w_enb = 1'b1;
        #1;
        expect_val("rdw_old", S_RDAT, 32'h2);
        check_now();
        @(posedge clk);
        #1;
        w_enb = 1'b0;
        expect_val("rdw_new", S_RDAT, 32'h55);
        check_now();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
